// File: rtl/phased_tag_lookup.sv
// Phased set-associative lookup controller: compares tags first, then reads
// exactly one data way; on a miss it requests a refill and rewrites a victim tag.
module phased_tag_lookup #(
  parameter int WAYS  = 4,
  parameter int TAG_W = 26,
  parameter int IDX_W = 2,
  parameter int OFF_W = 4,
  localparam int WAY_W  = $clog2(WAYS),
  localparam int LINE_W = 32 - OFF_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [31:0]             req_addr,
  output logic [IDX_W-1:0]        set_index,
  input  logic [WAYS*TAG_W-1:0]   set_tags,
  input  logic [WAYS-1:0]         set_valid,
  output logic [WAYS-1:0]         tag_we,
  output logic [TAG_W-1:0]        tag_wdata,
  output logic [WAYS-1:0]         data_re,
  input  logic [31:0]             data_in,
  output logic                    refill_req,
  output logic [31:0]             refill_addr,
  input  logic                    refill_done,
  output logic                    resp_valid,
  output logic                    resp_hit,
  output logic [WAY_W-1:0]        resp_way,
  output logic [31:0]             resp_data,
  output logic [15:0]             hit_count,
  output logic [15:0]             miss_count
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_TAG  = 3'd1;
  localparam logic [2:0] S_MISS = 3'd2;
  localparam logic [2:0] S_FILL = 3'd3;
  localparam logic [2:0] S_DATA = 3'd4;
  localparam logic [2:0] S_RESP = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [WAY_W-1:0]  way_q, way_d;
  logic              hit_q, hit_d;
  logic              from_ptr_q, from_ptr_d;
  logic [WAY_W-1:0]  ptr_q, ptr_d;
  logic [15:0]       hit_cnt_q, hit_cnt_d;
  logic [15:0]       miss_cnt_q, miss_cnt_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [TAG_W-1:0]  req_tag;
  logic              hit_found, inv_found;
  logic [WAY_W-1:0]  hit_way, inv_way;
  logic [WAYS-1:0]   way_onehot;

  assign req_tag    = line_q[LINE_W-1 -: TAG_W];
  assign way_onehot = {{(WAYS-1){1'b0}}, 1'b1} << way_q;

  // First-found scan gives lowest-index priority for both matches and invalid ways.
  always_comb begin
    hit_found = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!hit_found && set_valid[w] && (set_tags[w*TAG_W +: TAG_W] == req_tag)) begin
        hit_found = 1'b1;
        hit_way   = WAY_W'(w);
      end
      if (!inv_found && !set_valid[w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    way_d      = way_q;
    hit_d      = hit_q;
    from_ptr_d = from_ptr_q;
    ptr_d      = ptr_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    rdata_d    = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          line_d  = req_addr[31:OFF_W];
          state_d = S_TAG;
        end
      end
      S_TAG: begin
        if (hit_found) begin
          hit_d   = 1'b1;
          way_d   = hit_way;
          state_d = S_DATA;
          if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
        end else begin
          hit_d      = 1'b0;
          way_d      = inv_found ? inv_way : ptr_q;
          from_ptr_d = !inv_found;
          state_d    = S_MISS;
          if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
        end
      end
      S_MISS: begin
        if (refill_done) state_d = S_FILL;
      end
      S_FILL: begin
        // Round-robin pointer only moves when it actually chose the victim.
        if (from_ptr_q) ptr_d = ptr_q + WAY_W'(1);
        state_d = S_DATA;
      end
      S_DATA: state_d = S_RESP;
      S_RESP: begin
        rdata_d = data_in;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      line_q     <= '0;
      way_q      <= '0;
      hit_q      <= 1'b0;
      from_ptr_q <= 1'b0;
      ptr_q      <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      way_q      <= way_d;
      hit_q      <= hit_d;
      from_ptr_q <= from_ptr_d;
      ptr_q      <= ptr_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      rdata_q    <= rdata_d;
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign set_index   = line_q[IDX_W-1:0];
  assign tag_we      = (state_q == S_FILL) ? way_onehot : '0;
  assign tag_wdata   = (state_q == S_FILL) ? req_tag : '0;
  assign data_re     = (state_q == S_DATA) ? way_onehot : '0;
  assign refill_req  = (state_q == S_MISS);
  assign refill_addr = (state_q == S_MISS) ? {line_q, {OFF_W{1'b0}}} : '0;
  assign resp_valid  = (state_q == S_RESP);
  assign resp_hit    = (state_q == S_RESP) && hit_q;
  assign resp_way    = (state_q == S_RESP) ? way_q : '0;
  // Data arrives the cycle after data_re, so the response cycle forwards it directly.
  assign resp_data   = (state_q == S_RESP) ? data_in : rdata_q;
  assign hit_count   = hit_cnt_q;
  assign miss_count  = miss_cnt_q;

endmodule

// File: tb/tb_phased_tag_lookup.sv
// Self-checking bench for phased_tag_lookup: transaction-level model predicts
// every output per cycle; directed cases pin the model with literal values.
module tb_phased_tag_lookup;
  localparam int WAYS = 4, TAG_W = 26, IDX_W = 2, OFF_W = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  req_valid;
  logic                  req_ready;
  logic [31:0]           req_addr;
  logic [IDX_W-1:0]      set_index;
  logic [WAYS*TAG_W-1:0] set_tags;
  logic [WAYS-1:0]       set_valid;
  logic [WAYS-1:0]       tag_we;
  logic [TAG_W-1:0]      tag_wdata;
  logic [WAYS-1:0]       data_re;
  logic [31:0]           data_in;
  logic                  refill_req;
  logic [31:0]           refill_addr;
  logic                  refill_done;
  logic                  resp_valid;
  logic                  resp_hit;
  logic [1:0]            resp_way;
  logic [31:0]           resp_data;
  logic [15:0]           hit_count;
  logic [15:0]           miss_count;

  phased_tag_lookup #(.WAYS(WAYS), .TAG_W(TAG_W), .IDX_W(IDX_W), .OFF_W(OFF_W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .set_index(set_index), .set_tags(set_tags),
    .set_valid(set_valid), .tag_we(tag_we), .tag_wdata(tag_wdata),
    .data_re(data_re), .data_in(data_in), .refill_req(refill_req),
    .refill_addr(refill_addr), .refill_done(refill_done), .resp_valid(resp_valid),
    .resp_hit(resp_hit), .resp_way(resp_way), .resp_data(resp_data),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  bit hold_req = 1'b0;

  // Expected outputs for the current cycle.
  logic        e_ready, e_rreq, e_rvalid, e_rhit;
  logic [1:0]  e_idx, e_rway;
  logic [3:0]  e_we, e_re;
  logic [25:0] e_wdata;
  logic [31:0] e_raddr, e_rdata;
  logic [15:0] e_hc, e_mc;

  // Model state.
  logic [15:0] m_hc, m_mc;
  logic [1:0]  m_ptr, m_idx;
  logic [31:0] m_rdata;

  // Values observed during a transaction, for literal checks.
  logic [1:0]  c_idx, l_tag_idx, l_way;
  logic [3:0]  c_we, c_re, l_we, l_re;
  logic [25:0] c_wdata, l_wdata;
  logic [31:0] c_raddr, l_raddr;
  logic        c_hit, l_hit;
  logic [1:0]  c_way;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready",   32'(req_ready),   32'(e_ready));
      chk("set_index",   32'(set_index),   32'(e_idx));
      chk("tag_we",      32'(tag_we),      32'(e_we));
      chk("tag_wdata",   32'(tag_wdata),   32'(e_wdata));
      chk("data_re",     32'(data_re),     32'(e_re));
      chk("refill_req",  32'(refill_req),  32'(e_rreq));
      chk("refill_addr", refill_addr,      e_raddr);
      chk("resp_valid",  32'(resp_valid),  32'(e_rvalid));
      chk("resp_hit",    32'(resp_hit),    32'(e_rhit));
      chk("resp_way",    32'(resp_way),    32'(e_rway));
      chk("resp_data",   resp_data,        e_rdata);
      chk("hit_count",   32'(hit_count),   32'(e_hc));
      chk("miss_count",  32'(miss_count),  32'(e_mc));
    end
  end

  task automatic set_base(input bit ready);
    e_ready = ready; e_idx = m_idx; e_we = '0; e_wdata = '0; e_re = '0;
    e_rreq = 1'b0; e_raddr = '0; e_rvalid = 1'b0; e_rhit = 1'b0; e_rway = '0;
    e_rdata = m_rdata; e_hc = m_hc; e_mc = m_mc;
    data_in = $urandom;
    refill_done = ($urandom_range(0, 3) == 0);
  endtask

  task automatic busy_req();
    req_valid = hold_req ? 1'b1 : 1'($urandom_range(0, 1));
    req_addr  = $urandom;
  endtask

  task automatic step();
    @(negedge clk);
    c_idx = set_index; c_we = tag_we; c_wdata = tag_wdata; c_re = data_re;
    c_raddr = refill_addr; c_hit = resp_hit; c_way = resp_way;
    @(posedge clk);
    #1;
  endtask

  task automatic gap();
    set_base(1'b1);
    req_valid = 1'b0;
    req_addr  = $urandom;
    step();
  endtask

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [WAYS*TAG_W-1:0] mk_tags(input logic [25:0] avoid);
    logic [WAYS*TAG_W-1:0] t;
    logic [25:0] one;
    for (int w = 0; w < WAYS; w++) begin
      one = 26'($urandom);
      if (one == avoid) one = one ^ 26'h1;
      t[w*TAG_W +: TAG_W] = one;
    end
    return t;
  endfunction

  task automatic lookup(input logic [31:0] addr, input logic [WAYS*TAG_W-1:0] tags,
                        input logic [WAYS-1:0] valid, input int delay, input bit abort);
    logic [25:0] tag;
    logic [1:0]  idx, way;
    logic [3:0]  oh;
    bit          hit, useptr;
    tag = addr[31:6];
    idx = addr[5:4];
    hit = 1'b0; useptr = 1'b0; way = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (valid[w] && tags[w*TAG_W +: TAG_W] == tag) begin hit = 1'b1; way = 2'(w); end
    if (!hit) begin
      useptr = 1'b1; way = m_ptr;
      for (int w = WAYS - 1; w >= 0; w--)
        if (!valid[w]) begin useptr = 1'b0; way = 2'(w); end
    end
    oh = 4'b0001 << way;

    set_base(1'b1);
    req_valid = 1'b1; req_addr = addr; set_tags = tags; set_valid = valid;
    step();
    m_idx = idx;

    set_base(1'b0); busy_req(); step();
    l_tag_idx = c_idx;
    if (hit) m_hc = sat_inc(m_hc); else m_mc = sat_inc(m_mc);

    if (!hit) begin
      for (int i = 0; i <= delay; i++) begin
        set_base(1'b0); busy_req();
        e_rreq = 1'b1; e_raddr = {addr[31:4], 4'h0};
        refill_done = (i == delay);
        step();
        l_raddr = c_raddr;
        if (abort && i == 1) begin
          chk_en = 1'b0;
          reset = 1'b0;
          #1;
          chk("abort_refill_req", 32'(refill_req), 32'd0);
          chk("abort_resp_valid", 32'(resp_valid), 32'd0);
          chk("abort_req_ready",  32'(req_ready),  32'd1);
          m_hc = '0; m_mc = '0; m_ptr = '0; m_idx = '0; m_rdata = '0;
          req_valid = 1'b0;
          @(posedge clk);
          #1;
          reset = 1'b1;
          set_base(1'b1);
          req_valid = 1'b0;
          refill_done = 1'b1;
          chk_en = 1'b1;
          step();
          return;
        end
      end
      set_base(1'b0); busy_req(); e_we = oh; e_wdata = tag;
      step();
      l_we = c_we; l_wdata = c_wdata;
      if (useptr) m_ptr = m_ptr + 2'd1;
    end

    set_base(1'b0); busy_req(); e_re = oh;
    step();
    l_re = c_re;

    set_base(1'b0); busy_req();
    e_rvalid = 1'b1; e_rhit = hit; e_rway = way; e_rdata = data_in;
    m_rdata = data_in;
    step();
    l_hit = c_hit; l_way = c_way;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [WAYS*TAG_W-1:0] tags;
    logic [WAYS-1:0]       valid;
    logic [31:0]           addr;
    logic [1:0]            exp_way [5];
    int                    mode, w1, w2;

    reset = 1'b0; req_valid = 1'b0; req_addr = '0; set_tags = '0; set_valid = '0;
    data_in = '0; refill_done = 1'b0;
    m_hc = '0; m_mc = '0; m_ptr = '0; m_idx = '0; m_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready",  32'(req_ready),  32'd1);
    chk("rst_refill_req", 32'(refill_req), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_tag_we",     32'(tag_we),     32'd0);
    chk("rst_data_re",    32'(data_re),    32'd0);
    chk("rst_set_index",  32'(set_index),  32'd0);
    chk("rst_resp_data",  resp_data,       32'd0);
    chk("rst_hit_count",  32'(hit_count),  32'd0);
    chk("rst_miss_count", 32'(miss_count), 32'd0);
    reset = 1'b1;
    chk_en = 1'b1;
    gap();

    // Single valid way hits.
    tags = mk_tags(26'h0ABCDEF);
    tags[2*TAG_W +: TAG_W] = 26'h0ABCDEF;
    lookup({26'h0ABCDEF, 2'b01, 4'h0}, tags, 4'b0100, 0, 1'b0);
    chk("t1_set_index", 32'(l_tag_idx), 32'd1);
    chk("t1_data_re",   32'(l_re),      32'h4);
    chk("t1_resp_hit",  32'(l_hit),     32'd1);
    chk("t1_resp_way",  32'(l_way),     32'd2);
    chk("t1_hit_count", 32'(hit_count), 32'd1);

    // Miss with an invalid way available.
    lookup(32'h12345678, mk_tags(26'h048D159), 4'b1011, 2, 1'b0);
    chk("t2_refill_addr", l_raddr,         32'h12345670);
    chk("t2_tag_we",      32'(l_we),       32'h4);
    chk("t2_tag_wdata",   32'(l_wdata),    32'h048D159);
    chk("t2_data_re",     32'(l_re),       32'h4);
    chk("t2_resp_hit",    32'(l_hit),      32'd0);
    chk("t2_resp_way",    32'(l_way),      32'd2);
    chk("t2_miss_count",  32'(miss_count), 32'd1);

    // All ways valid: round-robin victims.
    exp_way = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 5; i++) begin
      addr = $urandom;
      lookup(addr, mk_tags(addr[31:6]), 4'b1111, i % 3, 1'b0);
      chk("t3_victim", 32'(l_way), 32'(exp_way[i]));
    end

    // Duplicate matching tags in ways 1 and 3.
    addr = $urandom;
    tags = mk_tags(addr[31:6]);
    tags[1*TAG_W +: TAG_W] = addr[31:6];
    tags[3*TAG_W +: TAG_W] = addr[31:6];
    lookup(addr, tags, 4'b1111, 0, 1'b0);
    chk("t4_resp_way", 32'(l_way), 32'd1);
    chk("t4_data_re",  32'(l_re),  32'h2);
    gap();

    // Reset while a refill is outstanding.
    lookup(32'hCAFE_0040, mk_tags(26'h32BF801), 4'b1111, 4, 1'b1);
    repeat (3) gap();
    chk("t5_miss_count", 32'(miss_count), 32'd0);

    // Randomised traffic.
    for (int n = 0; n < 60; n++) begin
      addr  = $urandom;
      valid = 4'($urandom);
      tags  = mk_tags(addr[31:6]);
      mode  = $urandom_range(0, 2);
      w1    = $urandom_range(0, 3);
      w2    = $urandom_range(0, 3);
      if (mode >= 1) begin valid[w1] = 1'b1; tags[w1*TAG_W +: TAG_W] = addr[31:6]; end
      if (mode == 2) begin valid[w2] = 1'b1; tags[w2*TAG_W +: TAG_W] = addr[31:6]; end
      lookup(addr, tags, valid, $urandom_range(0, 3), 1'b0);
      if ($urandom_range(0, 2) == 0) gap();
    end

    // Counter saturation, with req_valid held high throughout.
    set_base(1'b1);
    req_valid = 1'b0;
    force dut.hit_cnt_q  = 16'hFFFE;
    force dut.miss_cnt_q = 16'hFFFE;
    m_hc = 16'hFFFE; m_mc = 16'hFFFE;
    e_hc = m_hc; e_mc = m_mc;
    step();
    release dut.hit_cnt_q;
    release dut.miss_cnt_q;
    hold_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addr = $urandom;
      tags = mk_tags(addr[31:6]);
      tags[0 +: TAG_W] = addr[31:6];
      lookup(addr, tags, 4'b0001, 0, 1'b0);
    end
    chk("t6_hit_sat", 32'(hit_count), 32'hFFFF);
    for (int i = 0; i < 2; i++) begin
      addr = $urandom;
      lookup(addr, mk_tags(addr[31:6]), 4'b1111, 1, 1'b0);
    end
    chk("t6_miss_sat", 32'(miss_count), 32'hFFFF);
    hold_req = 1'b0;
    gap();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
